// File: rtl/uc_out_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uc_out_arbiter_pkg
// Shared definitions for the host-bound uc_out command bus:
//   - bit positions of the length/address/cmd/dataout fields in uc_out
//   - command codes used by the requester blocks
//   - arbiter state encoding
//   - pack_uc_out(): assembles the 22-bit bus word from its fields
// ---------------------------------------------------------------------------
package uc_out_arbiter_pkg;

    localparam int UC_OUT_W          = 22;
    localparam int UC_DATAOUT_START  = 0;
    localparam int UC_DATAOUT_END    = 7;
    localparam int UC_CMD_START      = 8;
    localparam int UC_CMD_END        = 10;
    localparam int UC_ADDRESS_START  = 11;
    localparam int UC_ADDRESS_END    = 13;
    localparam int UC_LENGTH_START   = 14;
    localparam int UC_LENGTH_END     = 21;

    localparam logic [2:0] IDLE_CMD        = 3'h0;
    localparam logic [2:0] TRIGGER_OUT_CMD = 3'h1;
    localparam logic [2:0] PIPE_OUT_CMD    = 3'h2;
    localparam logic [2:0] WIRE_OUT_CMD    = 3'h3;
    localparam logic [2:0] STATUS_CMD      = 3'h4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    function automatic logic [UC_OUT_W-1:0] pack_uc_out(
        input logic [7:0] len,
        input logic [2:0] addr,
        input logic [2:0] cmd,
        input logic [7:0] data
    );
        logic [UC_OUT_W-1:0] w;
        w = '0;
        w[UC_LENGTH_END:UC_LENGTH_START]   = len;
        w[UC_ADDRESS_END:UC_ADDRESS_START] = addr;
        w[UC_CMD_END:UC_CMD_START]         = cmd;
        w[UC_DATAOUT_END:UC_DATAOUT_START] = data;
        return w;
    endfunction

endpackage

// File: rtl/uc_out_arbiter_rr_arbiter_pick.sv
// ---------------------------------------------------------------------------
// rr_arbiter_pick
// Combinational round-robin priority search.
//   req_i    : request vector, one bit per requester
//   last_i   : index of the previous grantee (search starts at last_i+1)
//   winner_o : first set request found scanning last_i+1, last_i+2, ...
//              modulo NUM_REQ
//   valid_o  : at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [2:0]         last_i,
    output logic [2:0]         winner_o,
    output logic               valid_o
);

    always_comb begin : pick
        int idx;
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = 0;
        // k = NUM_REQ wraps back onto last_i itself, so a lone requester that
        // was just served can still win.  Modulo keeps the scan inside
        // 0..NUM_REQ-1 rather than the 3-bit index range.
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_i) + k) % NUM_REQ;
            if (!valid_o && req_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = 3'(idx);
            end
        end
    end

endmodule

// File: rtl/uc_out_arbiter.sv
// ---------------------------------------------------------------------------
// uc_out_arbiter
// Shares the host-bound uc_out command bus between NUM_REQ requesters using
// round-robin arbitration. The winner's fields are latched and held on uc_out
// for HOLD_CYCLES cycles, followed by GAP_CYCLES all-zero cycles so the host
// sees distinct commands.
//
// Handshake: a requester raises req[i] with its fields and keeps req high
// until ack[i]. ack[i] is a one-cycle pulse in the last GAP cycle. The
// requester drops req on the following edge, or keeps it high to post a
// new command. Fields are sampled only at the grant edge. Dropping req
// after the grant does not cancel the command.
//
// Ports:
//   uc_clk, uc_reset        clock, synchronous active-high reset
//   req[NUM_REQ]            level request per requester
//   req_cmd/req_addr        packed 3-bit fields, requester i at [3i+2:3i]
//   req_len/req_data        packed 8-bit fields, requester i at [8i+7:8i]
//   ack[NUM_REQ]            completion pulse to the served requester
//   busy                    high while in DRIVE or GAP
//   grant_id                index of current or last grantee
//   uc_out[22]              {length, address, cmd, dataout}
//   dbg_state               current arbiter state (arb_state_e encoding)
// ---------------------------------------------------------------------------
module uc_out_arbiter
    import uc_out_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                   uc_clk,
    input  logic                   uc_reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   req_cmd,
    input  logic [3*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_len,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic [UC_OUT_W-1:0]    uc_out,
    output logic [1:0]             dbg_state
);

    localparam int MAX_PHASE = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W     = $clog2(MAX_PHASE + 1);

    arb_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [2:0]            last_q;
    logic [2:0]            grant_q;
    logic [UC_OUT_W-1:0]   lat_q;
    logic [UC_OUT_W-1:0]   uc_out_q;
    logic [NUM_REQ-1:0]    ack_q;
    logic                  busy_q;

    logic [2:0]            winner;
    logic                  pick_valid;
    int                    wi;
    logic [UC_OUT_W-1:0]   win_word;

    rr_arbiter_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i    (req),
        .last_i   (last_q),
        .winner_o (winner),
        .valid_o  (pick_valid)
    );

    always_comb begin
        wi       = int'(winner);
        win_word = pack_uc_out(req_len[8*wi +: 8], req_addr[3*wi +: 3],
                               req_cmd[3*wi +: 3], req_data[8*wi +: 8]);
    end

    always_ff @(posedge uc_clk) begin
        if (uc_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            last_q   <= 3'(NUM_REQ - 1);
            grant_q  <= '0;
            lat_q    <= '0;
            uc_out_q <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    uc_out_q <= '0;
                    ack_q    <= '0;
                    busy_q   <= 1'b0;
                    if (pick_valid) begin
                        lat_q    <= win_word;
                        uc_out_q <= win_word;
                        grant_q  <= winner;
                        last_q   <= winner;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    uc_out_q <= lat_q;
                    if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                        cnt_q    <= '0;
                        uc_out_q <= '0;
                        state_q  <= ST_GAP;
                        // With a single gap cycle the ack lands right away.
                        if (GAP_CYCLES == 1) ack_q <= NUM_REQ'(1) << grant_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    uc_out_q <= '0;
                    if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        ack_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        // Raise ack for the cycle that will be the last gap cycle.
                        if (cnt_q + CNT_W'(1) == CNT_W'(GAP_CYCLES - 1))
                            ack_q <= NUM_REQ'(1) << grant_q;
                        else
                            ack_q <= '0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    cnt_q    <= '0;
                    uc_out_q <= '0;
                    ack_q    <= '0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ack       = ack_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;
    assign uc_out    = uc_out_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uc_out_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uc_out_arbiter
// Directed bench for uc_out_arbiter (NUM_REQ=4, HOLD=4, GAP=1).
// The stimulus process pushes one expected completion record per command
// into exp_q. The monitor rebuilds a record from the bus each time ack
// pulses, then pops exp_q and compares. A record holds:
//   {ack one-hot, word seen on the first busy cycle, busy cycles up to ack,
//    word held steady for HOLD cycles then zero}
// ---------------------------------------------------------------------------
module tb_uc_out_arbiter;

    localparam int NREQ = 4;
    localparam int HOLD = 4;
    localparam int GAP  = 1;
    localparam int EW   = 4 + 22 + 4 + 1;

    logic                clk = 1'b0;
    logic                uc_reset;
    logic [NREQ-1:0]     req;
    logic [3*NREQ-1:0]   req_cmd;
    logic [3*NREQ-1:0]   req_addr;
    logic [8*NREQ-1:0]   req_len;
    logic [8*NREQ-1:0]   req_data;
    logic [NREQ-1:0]     ack;
    logic                busy;
    logic [2:0]          grant_id;
    logic [21:0]         uc_out;
    logic [1:0]          dbg_state;

    int                  n_vec = 0;
    int                  n_err = 0;
    logic [EW-1:0]       exp_q[$];
    int                  pend[NREQ];
    int                  cyc_now = 0;
    int                  ack_t[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    uc_out_arbiter #(
        .NUM_REQ     (NREQ),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .uc_clk    (clk),
        .uc_reset  (uc_reset),
        .req       (req),
        .req_cmd   (req_cmd),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_data  (req_data),
        .ack       (ack),
        .busy      (busy),
        .grant_id  (grant_id),
        .uc_out    (uc_out),
        .dbg_state (dbg_state)
    );

    // ---------------- helpers / driver tasks ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic drive_req();
        for (int i = 0; i < NREQ; i++) req[i] = (pend[i] > 0);
    endtask

    // One cycle: land on the negedge, play each requester's registered response
    // to ack (consume one pending command), then update req.
    task automatic tick();
        @(negedge clk);
        cyc_now++;
        if (!uc_reset) begin
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    ack_t.push_back(cyc_now);
                    if (pend[i] > 0) pend[i]--;
                end
            end
        end
        drive_req();
    endtask

    task automatic set_fields(input int id, input logic [7:0] len, input logic [2:0] addr,
                              input logic [2:0] cmd, input logic [7:0] data);
        req_len[8*id +: 8]  = len;
        req_addr[3*id +: 3] = addr;
        req_cmd[3*id +: 3]  = cmd;
        req_data[8*id +: 8] = data;
    endtask

    function automatic logic [EW-1:0] mk_exp(input int id);
        logic [3:0] oh;
        oh = 4'(1) << id;
        return {oh, req_len[8*id +: 8], req_addr[3*id +: 3], req_cmd[3*id +: 3],
                req_data[8*id +: 8], 4'(HOLD + GAP), 1'b1};
    endfunction

    task automatic do_reset(input int cycles);
        uc_reset = 1'b1;
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        drive_req();
        for (int c = 0; c < cycles; c++) tick();
        uc_reset = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int t = 0; t < 300; t++) begin
            tick();
            if (exp_q.size() == 0 && !busy) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL %s: timeout with %0d completions outstanding, expected 0", name, exp_q.size());
    endtask

    // ---------------- scoreboard monitor ----------------
    int          m_cyc = 0;
    logic [21:0] m_word = '0;
    logic        m_ok = 1'b1;
    logic        m_after = 1'b0;

    always @(negedge clk) begin : monitor
        logic [EW-1:0] act;
        logic [EW-1:0] expv;
        if (uc_reset) begin
            m_cyc   = 0;
            m_ok    = 1'b1;
            m_after = 1'b0;
        end else begin
            if (ack != '0 && uc_out != '0) begin
                n_vec++;
                n_err++;
                $display("FAIL ack_bus_overlap: ack=%0h uc_out=%0h, required one of them zero", ack, uc_out);
            end
            if (m_after) begin
                n_vec++;
                if (busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL busy_after_ack: got %0b expected 0", busy);
                end
                m_after = 1'b0;
            end
            if (busy) begin
                m_cyc++;
                if (m_cyc == 1) m_word = uc_out;
                else if (m_cyc <= HOLD && uc_out !== m_word) m_ok = 1'b0;
                else if (m_cyc > HOLD && uc_out !== '0) m_ok = 1'b0;
            end
            if (ack != '0) begin
                act = {ack, m_word, 4'(m_cyc), m_ok};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_ack: got %0h expected no completion", act);
                end else begin
                    expv = exp_q.pop_front();
                    if (act !== expv) begin
                        n_err++;
                        $display("FAIL completion: got %0h expected %0h", act, expv);
                    end
                end
                m_after = 1'b1;
                m_cyc   = 0;
                m_ok    = 1'b1;
            end
            if (!busy) begin
                m_cyc = 0;
                m_ok  = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        uc_reset = 1'b1;
        req      = '0;
        req_cmd  = '0;
        req_addr = '0;
        req_len  = '0;
        req_data = '0;
        for (int i = 0; i < NREQ; i++) pend[i] = 0;

        // Reset then idle
        do_reset(2);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("idle_after_reset", {uc_out, ack, busy, grant_id}, 64'h0);
        end

        // Single request on requester 2: bus valid one cycle after req
        set_fields(2, 8'h10, 3'h2, 3'h1, 8'hA5);
        exp_q.push_back(mk_exp(2));
        pend[2] = 1;
        drive_req();
        tick();
        chk("single_latency", {busy, uc_out}, {1'b1, 8'h10, 3'h2, 3'h1, 8'hA5});
        wait_done("single");

        // Contention from a fresh pointer: order 0,1,3 then 0 again
        do_reset(2);
        set_fields(0, 8'h01, 3'h0, 3'h1, 8'h10);
        set_fields(1, 8'h02, 3'h1, 3'h2, 8'h20);
        set_fields(3, 8'h04, 3'h3, 3'h3, 8'h30);
        exp_q.push_back(mk_exp(0));
        exp_q.push_back(mk_exp(1));
        exp_q.push_back(mk_exp(3));
        exp_q.push_back(mk_exp(0));
        ack_t.delete();
        pend[0] = 2;
        pend[1] = 1;
        pend[3] = 1;
        drive_req();
        wait_done("contention");
        chk("contention_ack_count", 64'(ack_t.size()), 64'd4);
        if (ack_t.size() == 4) begin
            for (int k = 1; k < 4; k++)
                chk("contention_slot_spacing", 64'(ack_t[k] - ack_t[k-1]), 64'd6);
        end

        // Fairness: 0 keeps re-requesting, 3 (cmd=0, all-zero word) arrives
        // mid-command and must take the very next slot
        set_fields(0, 8'h55, 3'h5, 3'h2, 8'h0F);
        set_fields(3, 8'h00, 3'h0, 3'h0, 8'h00);
        exp_q.push_back(mk_exp(0));
        exp_q.push_back(mk_exp(3));
        exp_q.push_back(mk_exp(0));
        exp_q.push_back(mk_exp(0));
        pend[0] = 3;
        drive_req();
        tick();
        tick();
        pend[3] = 1;
        drive_req();
        wait_done("fairness");

        // Field isolation: requester data changes during DRIVE
        set_fields(0, 8'h40, 3'h1, 3'h2, 8'h11);
        exp_q.push_back(mk_exp(0));
        pend[0] = 1;
        drive_req();
        tick();
        tick();
        req_data[7:0] = 8'hFF;
        tick();
        chk("field_isolation", 64'(uc_out[7:0]), 64'h11);
        wait_done("isolation");

        // Reset on the 2nd hold cycle: abort, no ack, pointer back to NUM_REQ-1
        set_fields(0, 8'h33, 3'h3, 3'h4, 8'h22);
        pend[0] = 1;
        drive_req();
        tick();
        tick();
        uc_reset = 1'b1;
        pend[0] = 0;
        drive_req();
        tick();
        uc_reset = 1'b0;
        chk("reset_abort", {uc_out, ack, busy, grant_id}, 64'h0);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("no_ack_after_abort", 64'(ack), 64'h0);
        end
        set_fields(3, 8'h77, 3'h6, 3'h4, 8'h99);
        exp_q.push_back(mk_exp(0));
        exp_q.push_back(mk_exp(3));
        pend[0] = 1;
        pend[3] = 1;
        drive_req();
        wait_done("post_reset");

        tick();
        chk("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
